// File: rtl/wb_pkg.sv
// Shared widths, entry type and constants for the write-back port arbiter.
package wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write circular buffer: up to two in-order writes and one read per cycle.
// Every slot is exposed so the arbiter can search it for forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  ADDR_W = ADDR_W_DEF,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push0_i,
    input  logic [ADDR_W-1:0]            push0_addr_i,
    input  logic [DATA_W-1:0]            push0_data_i,
    input  logic                         push1_i,
    input  logic [ADDR_W-1:0]            push1_addr_i,
    input  logic [DATA_W-1:0]            push1_data_i,
    input  logic                         pop_i,
    output logic [CNT_W-1:0]             count_o,
    output logic [PTR_W-1:0]             head_o,
    output logic [DEPTH-1:0]             valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] addr_o,
    output logic [DEPTH-1:0][DATA_W-1:0] data_o
);

    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [PTR_W-1:0]             tail_nxt_s;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [1:0]                   n_push_s;

    // Next-state for pointers, occupancy and per-slot valid bits
    always_comb begin
        tail_nxt_s = tail_q + PTR_W'(1);
        n_push_s   = {1'b0, push0_i} + {1'b0, push1_i};
        head_d     = pop_i ? (head_q + PTR_W'(1)) : head_q;
        tail_d     = tail_q + PTR_W'(n_push_s);
        count_d    = count_q + CNT_W'(n_push_s) - CNT_W'(pop_i);
        valid_d                = valid_q;
        valid_d[head_q]        = valid_q[head_q] & ~pop_i;
        valid_d[tail_q]        = valid_d[tail_q] | push0_i;
        valid_d[tail_nxt_s]    = valid_d[tail_nxt_s] | push1_i;
    end

    // Pointer/occupancy registers; payload slots only need writing on push
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            valid_q <= {DEPTH{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
        if (push0_i) begin
            addr_q[tail_q] <= push0_addr_i;
            data_q[tail_q] <= push0_data_i;
        end
        if (push1_i) begin
            addr_q[tail_nxt_s] <= push1_addr_i;
            data_q[tail_nxt_s] <= push1_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges two write-back lanes onto a single register-file write port, buffering
// surplus writes and offering youngest-value forwarding for uncommitted writes.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] wb_data_1,
    input  logic [ADDR_W-1:0] wb_addr_1,
    input  logic              reg_write_1,
    input  logic [DATA_W-1:0] wb_data_2,
    input  logic [ADDR_W-1:0] wb_addr_2,
    input  logic              reg_write_2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              hit_a,
    output logic              hit_b,
    output logic [DATA_W-1:0] fwd_a,
    output logic [DATA_W-1:0] fwd_b
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]             fifo_count_s;
    logic [PTR_W-1:0]             fifo_head_s;
    logic [DEPTH-1:0]             fifo_valid_s;
    logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr_s;
    logic [DEPTH-1:0][DATA_W-1:0] fifo_data_s;

    logic              stall_s, empty_s, pop_s;
    logic              eff1_s, eff2_s, keep1_s;
    logic              w0_v_s, w1_v_s;
    logic [ADDR_W-1:0] w0_addr_s, w1_addr_s;
    logic [DATA_W-1:0] w0_data_s, w1_data_s;
    logic              push0_s, push1_s;
    logic [ADDR_W-1:0] push0_addr_s, push1_addr_s;
    logic [DATA_W-1:0] push0_data_s, push1_data_s;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    assign stall_s = (fifo_count_s > CNT_W'(DEPTH - 2));
    assign empty_s = (fifo_count_s == CNT_W'(0));
    assign pop_s   = ~empty_s;

    // Filter and order the lanes (older first), then pick bypass or queue path
    always_comb begin
        eff1_s  = reg_write_1 && (wb_addr_1 != ADDR_W'(REG_ZERO));
        eff2_s  = reg_write_2 && (wb_addr_2 != ADDR_W'(REG_ZERO));
        keep1_s = eff1_s && !(eff2_s && (wb_addr_1 == wb_addr_2));
        if (keep1_s) begin
            w0_v_s    = ~stall_s;
            w0_addr_s = wb_addr_1;
            w0_data_s = wb_data_1;
            w1_v_s    = eff2_s && ~stall_s;
        end else begin
            w0_v_s    = eff2_s && ~stall_s;
            w0_addr_s = wb_addr_2;
            w0_data_s = wb_data_2;
            w1_v_s    = 1'b0;
        end
        w1_addr_s = wb_addr_2;
        w1_data_s = wb_data_2;

        if (empty_s) begin
            rf_we_d      = w0_v_s;
            rf_waddr_d   = w0_v_s ? w0_addr_s : rf_waddr_q;
            rf_wdata_d   = w0_v_s ? w0_data_s : rf_wdata_q;
            push0_s      = w1_v_s;
            push0_addr_s = w1_addr_s;
            push0_data_s = w1_data_s;
            push1_s      = 1'b0;
        end else begin
            rf_we_d      = 1'b1;
            rf_waddr_d   = fifo_addr_s[fifo_head_s];
            rf_wdata_d   = fifo_data_s[fifo_head_s];
            push0_s      = w0_v_s;
            push0_addr_s = w0_addr_s;
            push0_data_s = w0_data_s;
            push1_s      = w1_v_s;
        end
        push1_addr_s = w1_addr_s;
        push1_data_s = w1_data_s;
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push0_i      (push0_s),
        .push0_addr_i (push0_addr_s),
        .push0_data_i (push0_data_s),
        .push1_i      (push1_s),
        .push1_addr_i (push1_addr_s),
        .push1_data_i (push1_data_s),
        .pop_i        (pop_s),
        .count_o      (fifo_count_s),
        .head_o       (fifo_head_s),
        .valid_o      (fifo_valid_s),
        .addr_o       (fifo_addr_s),
        .data_o       (fifo_data_s)
    );

    // Register-file write port register
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_W{1'b0}};
            rf_wdata_q <= {DATA_W{1'b0}};
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Output register is oldest, so it is checked first and later queue slots override
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] qa);
        logic [DATA_W:0]  res;
        logic [PTR_W-1:0] idx;
        res = (rf_we_q && (rf_waddr_q == qa)) ? {1'b1, rf_wdata_q} : {(DATA_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = fifo_head_s + PTR_W'(i);
            res = (fifo_valid_s[idx] && (fifo_addr_s[idx] == qa)) ? {1'b1, fifo_data_s[idx]} : res;
        end
        return (qa == ADDR_W'(REG_ZERO)) ? {(DATA_W+1){1'b0}} : res;
    endfunction

    // Forwarding lookup for both query ports
    always_comb begin
        {hit_a, fwd_a} = lookup(q_addr_a);
        {hit_b, fwd_b} = lookup(q_addr_b);
    end

    assign stall    = stall_s;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: lane vectors with a write scoreboard plus stall/forward/reset sequences.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data_1, wb_data_2;
    logic [4:0]  wb_addr_1, wb_addr_2;
    logic        reg_write_1, reg_write_2;
    logic        stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr_a, q_addr_b;
    logic        hit_a, hit_b;
    logic [31:0] fwd_a, fwd_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    logic saw_stall = 1'b0;
    wb_entry_t sb[$];

    typedef struct {
        logic        rw1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        rw2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic [4:0]  qa;
        logic        exp_hit;
        logic [31:0] exp_fwd;
        int          exp_nw;
    } vec_t;
    vec_t vecs[8];

    wb_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wb_data_1   (wb_data_1),
        .wb_addr_1   (wb_addr_1),
        .reg_write_1 (reg_write_1),
        .wb_data_2   (wb_data_2),
        .wb_addr_2   (wb_addr_2),
        .reg_write_2 (reg_write_2),
        .stall       (stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .q_addr_a    (q_addr_a),
        .q_addr_b    (q_addr_b),
        .hit_a       (hit_a),
        .hit_b       (hit_b),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference filter: drop disabled / r0 writes, lane 2 wins a same-address tie
    task automatic model_push(input logic rw1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic rw2, input logic [4:0] a2, input logic [31:0] d2);
        logic e1, e2;
        e1 = rw1 && (a1 != 5'd0);
        e2 = rw2 && (a2 != 5'd0);
        if (e1 && e2 && (a1 == a2)) e1 = 1'b0;
        if (e1) sb.push_back('{addr: a1, data: d1});
        if (e2) sb.push_back('{addr: a2, data: d2});
    endtask

    // Present both lanes, hold them through stall, return one cycle after acceptance
    task automatic drive(input logic rw1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic rw2, input logic [4:0] a2, input logic [31:0] d2);
        int waits;
        reg_write_1 = rw1; wb_addr_1 = a1; wb_data_1 = d1;
        reg_write_2 = rw2; wb_addr_2 = a2; wb_data_2 = d2;
        waits = 0;
        while (stall && waits < 50) begin
            saw_stall = 1'b1;
            @(negedge clk); #1;
            waits++;
        end
        if (stall) begin
            n_cmp++; n_bad++;
            $display("FAIL drive_timeout stall got 1 required 0");
        end else begin
            model_push(rw1, a1, d1, rw2, a2, d2);
        end
        @(negedge clk); #1;
        reg_write_1 = 1'b0;
        reg_write_2 = 1'b0;
    endtask

    // Scoreboard: every committed write must match the next expected one in order
    always @(negedge clk) begin
        if (rf_we) begin
            wb_entry_t e;
            n_wr++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write got %0d/%0h required none", rf_waddr, rf_wdata);
            end else begin
                e = sb.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL write_order got %0d/%0h required %0d/%0h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        int w0;
        vecs[0] = '{1'b1, 5'd4,  32'hA,  1'b1, 5'd5,  32'hB,  5'd5,  1'b1, 32'hB,  2};
        vecs[1] = '{1'b1, 5'd7,  32'h1,  1'b1, 5'd7,  32'h2,  5'd7,  1'b1, 32'h2,  1};
        vecs[2] = '{1'b1, 5'd6,  32'h33, 1'b1, 5'd0,  32'hEE, 5'd0,  1'b0, 32'h0,  1};
        vecs[3] = '{1'b0, 5'd8,  32'h77, 1'b0, 5'd8,  32'h78, 5'd8,  1'b0, 32'h0,  0};
        vecs[4] = '{1'b0, 5'd10, 32'h40, 1'b1, 5'd11, 32'h44, 5'd10, 1'b0, 32'h0,  1};
        vecs[5] = '{1'b1, 5'd12, 32'h55, 1'b1, 5'd13, 32'h66, 5'd12, 1'b1, 32'h55, 2};
        vecs[6] = '{1'b1, 5'd14, 32'h77, 1'b0, 5'd15, 32'h11, 5'd14, 1'b1, 32'h77, 1};
        vecs[7] = '{1'b1, 5'd0,  32'h99, 1'b1, 5'd15, 32'h88, 5'd15, 1'b1, 32'h88, 1};

        reset = 1'b1;
        reg_write_1 = 1'b0; wb_addr_1 = 5'd0; wb_data_1 = 32'd0;
        reg_write_2 = 1'b0; wb_addr_2 = 5'd0; wb_data_2 = 32'd0;
        q_addr_a = 5'd3; q_addr_b = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_waddr", rf_waddr, 5'd0);
        check("reset_wdata", rf_wdata, 32'd0);
        check("reset_stall", stall, 1'b0);

        // Single lane on empty queue: bypass with one-cycle latency
        drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        check("bypass_we", rf_we, 1'b1);
        check("bypass_waddr", rf_waddr, 5'd3);
        check("bypass_wdata", rf_wdata, 32'h11);
        @(negedge clk); #1;
        check("bypass_we_drop", rf_we, 1'b0);

        for (int i = 0; i < 8; i++) begin
            w0 = n_wr;
            q_addr_a = vecs[i].qa;
            drive(vecs[i].rw1, vecs[i].a1, vecs[i].d1, vecs[i].rw2, vecs[i].a2, vecs[i].d2);
            check($sformatf("vec%0d_hit", i), hit_a, vecs[i].exp_hit);
            check($sformatf("vec%0d_fwd", i), fwd_a, vecs[i].exp_fwd);
            repeat (3) begin @(negedge clk); #1; end
            check($sformatf("vec%0d_nwrites", i), n_wr - w0, vecs[i].exp_nw);
        end

        // Back-to-back dual writes: stall must appear and nothing may be lost
        saw_stall = 1'b0;
        w0 = n_wr;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(16 + 2*k), 32'h100 + 32'(k), 1'b1, 5'(17 + 2*k), 32'h200 + 32'(k));
        end
        repeat (6) begin @(negedge clk); #1; end
        check("stream_saw_stall", saw_stall, 1'b1);
        check("stream_stall_low", stall, 1'b0);
        check("stream_nwrites", n_wr - w0, 10);
        check("stream_sb_empty", sb.size(), 0);

        // Two pending writes to r9: youngest must be forwarded
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23);
        drive(1'b1, 5'd24, 32'h24, 1'b1, 5'd9,  32'h5);
        drive(1'b1, 5'd9,  32'h6,  1'b1, 5'd25, 32'h25);
        q_addr_a = 5'd9; q_addr_b = 5'd0;
        #1;
        check("fwd9_hit", hit_a, 1'b1);
        check("fwd9_data", fwd_a, 32'h6);
        check("fwd0_hit", hit_b, 1'b0);
        check("fwd0_data", fwd_b, 32'h0);
        check("three_pending_stall", stall, 1'b1);

        // Reset with three pending writes discards them
        reset = 1'b1;
        sb.delete();
        @(negedge clk); #1;
        reset = 1'b0;
        check("midreset_we", rf_we, 1'b0);
        check("midreset_stall", stall, 1'b0);
        check("midreset_hit", hit_a, 1'b0);
        w0 = n_wr;
        repeat (5) begin @(negedge clk); #1; end
        check("midreset_no_stale", n_wr - w0, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the two superscalar write-back lanes onto a register file that has a single write port.
- Sits between the write-back muxes (data/destination per lane) and the register file.
- Drops writes that are disabled or target r0, and resolves same-cycle WAW conflicts.
- Buffers surplus writes, back-pressures the pipeline with a stall, and provides forwarding lookup for writes not yet committed.

Parameters:
- DEPTH, 4, pending-write queue entries (power of two, >= 2)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_data_1  in  DATA_W  lane 1 write-back value
- wb_addr_1  in  ADDR_W  lane 1 destination register
- reg_write_1  in  1  lane 1 write enable (older instruction)
- wb_data_2  in  DATA_W  lane 2 write-back value
- wb_addr_2  in  ADDR_W  lane 2 destination register
- reg_write_2  in  1  lane 2 write enable (younger instruction)
- stall  out  1  upstream must hold both lanes
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- q_addr_a, q_addr_b  in  ADDR_W  forwarding lookup addresses
- hit_a, hit_b  out  1  lookup matched a pending write
- fwd_a, fwd_b  out  DATA_W  youngest pending value for the address

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Effective write (lane k): reg_write_k=1 and wb_addr_k!=0. All other writes are dropped silently.
- WAW resolution: if both lanes are effective with equal addresses, lane 1 is dropped and only lane 2 is kept.
- Lane inputs are sampled only when stall=0. While stall=1 they are ignored, and upstream holds them.
- stall = (count > DEPTH-2), decoded combinationally from the registered count. It is 1 when fewer than 2 slots are free.
- Each edge with stall=0 processes the effective writes in program order (lane 1 first):
  - Queue empty: the first effective write loads the output register directly (bypass, latency 1 cycle). A second effective write is enqueued.
  - Queue non-empty: all effective writes are enqueued at the tail in order, and the head is popped into the output register.
- With stall=1 the head is still popped each cycle. The queue drains at 1 per cycle.
- Output register: rf_we=1 for exactly one cycle per committed write; otherwise rf_we=0. rf_waddr and rf_wdata hold their last values when rf_we=0.
- count is updated as count + enq - deq in the same cycle. Simultaneous enqueue of 2 and dequeue of 1 is legal. Overflow cannot occur because stall guards it.
- Head/tail pointers wrap modulo DEPTH.
- Forwarding lookup (combinational):
  - Search candidates are the valid queue entries plus the output register when rf_we=1.
  - The youngest match wins: tail-most queue entry first, the output register last.
  - Address 0 never hits.
  - On a miss, hit=0 and fwd=0.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, count=0, pointers=0, stall=0.
- Reset mid-operation discards all pending writes. The next cycle has rf_we=0.
- Write order to the register file always equals program order.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W defaults
  - the wb_entry_t typedef {addr, data}
  - the zero-register constant REG_ZERO = 0
- Sub-module wb_fifo:
  - 2-write/1-read circular buffer with count and per-entry valid
  - exposes all entries for the forwarding search
- The arbiter holds filtering, WAW resolution, bypass, the output register and the lookup.

Test Plan:
- Reset, then lane 1 only (addr 3, 0x11) on an empty queue -> next cycle rf_we=1, waddr=3, wdata=0x11; the following cycle rf_we=0.
- Both lanes (addr 4, 0xA; addr 5, 0xB) -> rf writes 4/0xA then 5/0xB on consecutive cycles; hit_a=1, fwd_a=0xB for q_addr_a=5 while pending.
- Both lanes targeting addr 7 (0x1, 0x2) -> a single write 7/0x2. Lane 2 targeting addr 0 -> dropped, with no rf_we for it.
- Dual writes every cycle with DEPTH=4 -> stall rises when count=3 and falls after draining. No write is lost or reordered (scoreboard of 10 writes).
- Queue with addr 9 holding 0x5 older and 0x6 younger -> fwd for q_addr 9 is 0x6. q_addr 0 -> hit=0.
- Assert reset with 3 pending entries -> next cycle rf_we=0, stall=0. No stale write appears afterwards.
